// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Brief    : N-channel push-button conditioner with a synchroniser, a debouncer
//            and a hold FSM per channel. The FSM emits press, release,
//            long-press and auto-repeat action strobes.
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
    parameter int               N_BTN        = 4,
    parameter int               SYNC_STAGES  = 2,
    parameter int               DEBOUNCE_CYC = 1_000_000,
    parameter int               LONG_CYC     = 100_000_000,
    parameter int               REPEAT_CYC   = 20_000_000,
    parameter logic [N_BTN-1:0] INVERT       = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_evt,  // "release" is a reserved word in SystemVerilog
    output logic [N_BTN-1:0] long_press,
    output logic [N_BTN-1:0] act
);

    localparam int c_DCNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int c_HMAX   = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int c_HCNT_W = $clog2(c_HMAX + 1);

    localparam logic [c_DCNT_W-1:0] c_DEB_LAST = c_DCNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [c_HCNT_W-1:0] c_LONG     = c_HCNT_W'(LONG_CYC);
    localparam logic [c_HCNT_W-1:0] c_REP      = c_HCNT_W'(REPEAT_CYC);
    localparam logic [c_HCNT_W-1:0] c_HONE     = c_HCNT_W'(1);

    localparam logic [1:0] c_ST_RELEASED = 2'd0;
    localparam logic [1:0] c_ST_HELD     = 2'd1;
    localparam logic [1:0] c_ST_REPEAT   = 2'd2;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;
        logic [c_DCNT_W-1:0]    r_dcnt;
        logic                   r_level;
        logic                   w_done;
        logic                   w_rise;
        logic                   w_fall;
        logic [1:0]             r_state;
        logic [1:0]             w_state_nxt;
        logic [c_HCNT_W-1:0]    r_hcnt;
        logic [c_HCNT_W-1:0]    w_hcnt_nxt;
        logic [c_HCNT_W-1:0]    w_hinc;
        logic                   w_press;
        logic                   w_rel;
        logic                   w_long;
        logic                   w_act;
        logic                   r_press;
        logic                   r_rel;
        logic                   r_long;
        logic                   r_act;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in[i] ^ INVERT[i]};
            end
        end

        assign w_s = r_sync[SYNC_STAGES-1];

        // The edge that would bring dcnt to DEBOUNCE_CYC flips the level instead.
        assign w_done = (w_s != r_level) && (r_dcnt == c_DEB_LAST);
        assign w_rise = w_done && !r_level;
        assign w_fall = w_done && r_level;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_dcnt  <= '0;
                r_level <= 1'b0;
            end else if (w_s != r_level) begin
                if (w_done) begin
                    r_level <= ~r_level;
                    r_dcnt  <= '0;
                end else begin
                    r_dcnt <= r_dcnt + c_DCNT_W'(1);
                end
            end else begin
                r_dcnt <= '0;
            end
        end

        assign w_hinc = r_hcnt + c_HONE;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state <= c_ST_RELEASED;
                r_hcnt  <= '0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                r_long  <= 1'b0;
                r_act   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_hcnt  <= w_hcnt_nxt;
                r_press <= w_press;
                r_rel   <= w_rel;
                r_long  <= w_long;
                r_act   <= w_act;
            end
        end

        // In HELD, hcnt parked at LONG_CYC marks "long-press already fired".
        always_comb begin
            w_state_nxt = r_state;
            w_hcnt_nxt  = r_hcnt;
            case (r_state)
                c_ST_RELEASED: begin
                    if (w_rise) begin
                        w_state_nxt = c_ST_HELD;
                        w_hcnt_nxt  = '0;
                    end
                end
                c_ST_HELD: begin
                    if (w_fall) begin
                        w_state_nxt = c_ST_RELEASED;
                        w_hcnt_nxt  = '0;
                    end else if (r_hcnt == c_LONG) begin
                        if (repeat_en[i]) begin
                            w_state_nxt = c_ST_REPEAT;
                            w_hcnt_nxt  = '0;
                        end
                    end else if (w_hinc == c_LONG) begin
                        if (repeat_en[i]) begin
                            w_state_nxt = c_ST_REPEAT;
                            w_hcnt_nxt  = '0;
                        end else begin
                            w_hcnt_nxt = c_LONG;
                        end
                    end else begin
                        w_hcnt_nxt = w_hinc;
                    end
                end
                c_ST_REPEAT: begin
                    if (w_fall) begin
                        w_state_nxt = c_ST_RELEASED;
                        w_hcnt_nxt  = '0;
                    end else if (repeat_en[i]) begin
                        w_hcnt_nxt = (w_hinc == c_REP) ? '0 : w_hinc;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_RELEASED;
                    w_hcnt_nxt  = '0;
                end
            endcase
        end

        always_comb begin
            w_press = w_rise;
            w_rel   = w_fall;
            w_long  = (r_state == c_ST_HELD) && !w_fall &&
                      (r_hcnt != c_LONG) && (w_hinc == c_LONG);
            w_act   = w_rise || (w_long && repeat_en[i]) ||
                      ((r_state == c_ST_REPEAT) && !w_fall && repeat_en[i] &&
                       (w_hinc == c_REP));
        end

        assign level[i]       = r_level;
        assign press[i]       = r_press;
        assign release_evt[i] = r_rel;
        assign long_press[i]  = r_long;
        assign act[i]         = r_act;
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_conditioner
// Brief    : Directed, table-driven bench for btn_conditioner (4 channels,
//            short debounce/long/repeat periods) plus an inverted-pin instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_in;
    logic [3:0] repeat_en;
    logic [3:0] level, press, rel, long_press, act;
    logic [3:0] level_i, press_i, rel_i, long_press_i, act_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_BTN(4), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .LONG_CYC(20),
        .REPEAT_CYC(5), .INVERT(4'b0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .repeat_en(repeat_en),
        .level(level), .press(press), .release_evt(rel),
        .long_press(long_press), .act(act)
    );

    btn_conditioner #(
        .N_BTN(4), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .LONG_CYC(20),
        .REPEAT_CYC(5), .INVERT(4'b0001)
    ) dut_inv (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .repeat_en(repeat_en),
        .level(level_i), .press(press_i), .release_evt(rel_i),
        .long_press(long_press_i), .act(act_i)
    );

    // Each row: inputs in force from edge `cyc` on, and the strobes expected
    // right after that edge. Edges without a row expect no strobes.
    typedef struct {
        int         scn;
        int         cyc;
        logic       rst_n;
        logic [3:0] btn;
        logic [3:0] rep;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
        logic [3:0] act;
    } row_t;

    row_t tbl[$];

    task automatic check(input string name, input int cyc,
                         input logic [19:0] got, input logic [19:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d lvl/prs/rel/lng/act got=%b_%b_%b_%b_%b exp=%b_%b_%b_%b_%b",
                     name, cyc, got[19:16], got[15:12], got[11:8], got[7:4], got[3:0],
                     exp[19:16], exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic check_rules(input string name, input int cyc);
        checks++;
        if (((press & rel) != 4'b0) || ((act & ~level) != 4'b0)) begin
            failures++;
            $display("FAIL %s_rules cyc=%0d press=%b rel=%b act=%b level=%b",
                     name, cyc, press, rel, act, level);
        end
    endtask

    task automatic run_scn(input int scn, input string name, input bit do_reset,
                           input logic [3:0] pre_btn);
        row_t       q[$];
        row_t       cur;
        int         idx = 0;
        int         last = 0;
        logic [3:0] lvl_exp = 4'b0;
        logic [3:0] ep, er, el, ea;
        foreach (tbl[k]) begin
            if (tbl[k].scn == scn) begin
                q.push_back(tbl[k]);
                if (tbl[k].cyc > last) last = tbl[k].cyc;
            end
        end
        if (do_reset) begin
            rst_n = 1'b0; btn_in = pre_btn; repeat_en = 4'b0;
            for (int r = 0; r < 3; r++) begin
                @(posedge clk); #1;
                check({name, "_reset"}, r, {level, press, rel, long_press, act}, 20'h0);
            end
        end
        for (int c = 0; c <= last; c++) begin
            ep = 4'b0; er = 4'b0; el = 4'b0; ea = 4'b0;
            if (idx < q.size() && q[idx].cyc == c) begin
                cur = q[idx];
                idx++;
                rst_n = cur.rst_n; btn_in = cur.btn; repeat_en = cur.rep;
                ep = cur.press; er = cur.rel; el = cur.lng; ea = cur.act;
            end
            @(posedge clk); #1;
            lvl_exp = !rst_n ? 4'b0 : ((lvl_exp | ep) & ~er);
            check(name, c, {level, press, rel, long_press, act}, {lvl_exp, ep, er, el, ea});
            check_rules(name, c);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=-1 got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; btn_in = 4'b0; repeat_en = 4'b0;

        // Debounce: ch0 held, ch1 3-cycle glitch then exactly 4-cycle pulse.
        tbl.push_back('{1,  0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1,  5, 1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001});
        tbl.push_back('{1, 10, 1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1, 13, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1, 20, 1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1, 24, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1, 25, 1'b1, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0010});
        tbl.push_back('{1, 29, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000});
        tbl.push_back('{1, 32, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        // Reset while ch0 is held, all pins high through deassertion.
        tbl.push_back('{2,  0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{2,  3, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{2,  8, 1'b1, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1111});
        tbl.push_back('{2, 12, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        // Long press and repeat; release lands on a repeat tick and wins.
        tbl.push_back('{3,  0, 1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{3,  5, 1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100});
        tbl.push_back('{3, 25, 1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100});
        tbl.push_back('{3, 30, 1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100});
        tbl.push_back('{3, 35, 1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100});
        tbl.push_back('{3, 40, 1'b1, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100});
        tbl.push_back('{3, 45, 1'b1, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000});
        tbl.push_back('{3, 50, 1'b1, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        // Repeat disabled at long-press, enabled later, paused and resumed.
        tbl.push_back('{4,  0, 1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{4,  5, 1'b1, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100});
        tbl.push_back('{4, 25, 1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000});
        tbl.push_back('{4, 32, 1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{4, 37, 1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100});
        tbl.push_back('{4, 42, 1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100});
        tbl.push_back('{4, 44, 1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{4, 48, 1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{4, 51, 1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100});
        tbl.push_back('{4, 54, 1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        // Simultaneous channels.
        tbl.push_back('{5,  0, 1'b1, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{5,  5, 1'b1, 4'b1011, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 4'b1011});
        tbl.push_back('{5, 10, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{5, 15, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 4'b0000});
        tbl.push_back('{5, 18, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000});

        run_scn(1, "debounce",   1'b1, 4'b0000);
        run_scn(2, "reset_held", 1'b0, 4'b0000);
        run_scn(3, "repeat",     1'b1, 4'b0000);
        run_scn(4, "norepeat",   1'b1, 4'b0000);
        run_scn(5, "simul",      1'b1, 4'b0000);

        // Active-low ch0 on the inverted instance; reset mid-hold, then a
        // button still held through deassertion is a fresh press.
        rst_n = 1'b0; btn_in = 4'b0001; repeat_en = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c <= 25; c++) begin
            logic       lv, pr;
            rst_n  = !(c >= 13 && c <= 15);
            btn_in = 4'b0000;
            @(posedge clk); #1;
            lv = ((c >= 5) && (c <= 12)) || (c >= 21);
            pr = (c == 5) || (c == 21);
            check("invert_midreset", c,
                  {level_i, press_i, rel_i, long_press_i, act_i},
                  {3'b000, lv, 3'b000, pr, 4'b0000, 4'b0000, 3'b000, pr});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
